cdb_arbiter: RTL and testbench
==============================

// Module: cdb_arbiter
// PURPOSE
//  Arbitrates the two-lane common data bus between the result producers: reorder buffer, ALU, mult/div,
//  load/store and branch units. Each cycle, grants at most BUSES requesters, at most one per lane.
//  Grants are registered; a granted unit drives its result on its assigned lane in the grant cycle.
//  Rotating (round-robin) priority gives fairness. Sits beside the data_bus interfaces in cpu.
// PARAMETERS
//  REQUESTERS  5  number of result producers; index = ARBITER_ADDRESS-1
//  BUSES       2  number of common data bus lanes
//  STARVE_MAX  7  wait-cycle limit for the starvation override (used only with CDB_ARB_STARVE_EN)
// PORTS
//  clock          in   1                          system clock, all state on rising edge
//  reset          in   1                          synchronous, active-high
//  clear          in   1                          pipeline flush (global_bus clear), synchronous
//  request        in   REQUESTERS                 req[i]=1: unit i holds a result ready to broadcast
//  bus_available  in   BUSES                      lane k may be granted this arbitration
//  grant          out  REQUESTERS                 grant[i]=1: unit i drives its lane this cycle
//  grant_lane     out  REQUESTERS*LW              lane for unit i; LW=max(1,$clog2(BUSES))
//  lane_valid     out  BUSES                      lane k carries a granted result this cycle
//  lane_owner     out  BUSES*OW                   requester index on lane k; OW=max(1,$clog2(REQUESTERS))
// BEHAVIOUR
//  - Reset and clear: all outputs 0, round-robin pointer ptr=0, wait counters 0. Values take effect the cycle after.
//  - Latency: request sampled at edge t -> grant visible for cycle t+1. A grant lasts exactly one cycle.
//  - Eligible(i) = request[i] & ~grant[i]. A unit granted in cycle t is masked at the edge ending t.
//    Its request may still be stale at that edge, so it cannot be granted in back-to-back cycles.
//  - Scan order: ptr, ptr+1, ..., mod REQUESTERS. Walk the available lanes in ascending lane index.
//    The 1st eligible unit gets the lowest available lane, the 2nd eligible unit the next available lane, and so on.
//  - Pointer: if there is at least one grant, ptr <= (index of last granted unit + 1) mod REQUESTERS.
//    If there are no grants, ptr holds.
//  - No available lane or no eligible request: all grants 0, ptr holds.
//  - grant_lane[i] and lane_owner[k] are meaningful only when grant[i] / lane_valid[k] is 1. Otherwise they are 0.
//  - Invariants: popcount(grant) == popcount(lane_valid) <= BUSES. No two lanes have the same owner.
//  - Requester contract: hold request until granted.
//    On grant, present the result on lane grant_lane[i] in that cycle and drop request if nothing remains.
//  - Simultaneous clear and request: clear wins; no grants in the next cycle.
//  - reset has priority over clear.
// CONFIGURATION
//  CDB_ARB_STARVE_EN defined:
//    - Each requester has a wait counter of $clog2(STARVE_MAX+1) bits.
//    - The counter increments (saturating) while request[i]=1 & grant[i]=0. It resets to 0 on grant or on clear.
//    - An eligible unit whose counter == STARVE_MAX is starved. Starved units take lanes first, lowest index first.
//      Remaining lanes then follow the normal rotating scan.
//    - A starvation grant does not move ptr unless it is also the last granted unit.
//  CDB_ARB_STARVE_EN undefined: no counters; pure round-robin as above.
// TESTING
//  1 reset=1 for 2 cycles with request=5'b11111 -> grant=0, lane_valid=0. First grants appear on cycle 2 after reset falls.
//  2 ptr=0; request=5'b10110, both lanes available -> next cycle grant=5'b00110, unit1 on lane0, unit2 on lane1, ptr=3.
//    The following cycle: grant=5'b10000, unit4 on lane0, lane1 invalid, ptr=0.
//  3 request held at 5'b11111 for 10 cycles -> grant sequence {0,1},{2,3},{4,0},{1,2},...
//    Back-to-back masking is visible: {0,1} is never followed by a grant to unit 1.
//  4 bus_available=2'b10, request=5'b00011 -> unit0 gets lane1 only, lane_valid=2'b10. Unit1 is granted on lane1 two cycles later.
//  5 clear pulsed while request=5'b01000 -> no grant the following cycle, ptr=0. Unit3 is granted the cycle after that.
//  6 CDB_ARB_STARVE_EN, STARVE_MAX=3, bus_available=2'b01:
//    unit4 requests continuously while units 0-3 re-request every cycle. Unit4 is granted lane0 within 5 cycles.

Source files
------------

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: registered rotating-priority grant of the common data bus lanes.
// Define CDB_ARB_STARVE_EN to add the per-requester starvation override.
module cdb_arbiter #(
    parameter int REQUESTERS = 5,
    parameter int BUSES      = 2,
    parameter int STARVE_MAX = 7,
    localparam int LW = (BUSES > 1) ? $clog2(BUSES) : 1,
    localparam int OW = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     clear,
    input  logic [REQUESTERS-1:0]    request,
    input  logic [BUSES-1:0]         bus_available,
    output logic [REQUESTERS-1:0]    grant,
    output logic [REQUESTERS*LW-1:0] grant_lane,
    output logic [BUSES-1:0]         lane_valid,
    output logic [BUSES*OW-1:0]      lane_owner
);

    localparam int CW = $clog2(STARVE_MAX + 1);

    logic [REQUESTERS-1:0]    elig;
    logic [REQUESTERS-1:0]    starved;
    logic [REQUESTERS-1:0]    nxt_grant;
    logic [REQUESTERS*LW-1:0] nxt_lane;
    logic [BUSES-1:0]         nxt_valid;
    logic [BUSES*OW-1:0]      nxt_owner;
    logic [BUSES-1:0]         free;
    logic [OW-1:0]            ptr;
    logic [OW-1:0]            last;
    logic [OW-1:0]            nxt_ptr;
    logic [LW-1:0]            lane;
    logic                     any;
    logic                     pick;
    int                       idx;

    function automatic logic [LW-1:0] lowest(input logic [BUSES-1:0] f);
        logic [LW-1:0] r;
        r = '0;
        for (int k = BUSES - 1; k >= 0; k--)
            if (f[k]) r = LW'(k);
        return r;
    endfunction

    // Pass 0..R-1 serves starved units by index, pass R..2R-1 is the rotating scan.
    always_comb begin
        nxt_grant = '0;
        nxt_lane  = '0;
        nxt_valid = '0;
        nxt_owner = '0;
        free      = bus_available;
        last      = ptr;
        any       = 1'b0;
        lane      = '0;
        pick      = 1'b0;
        idx       = 0;
        elig      = request & ~grant;
        for (int p = 0; p < 2 * REQUESTERS; p++) begin
            if (p < REQUESTERS) begin
                idx  = p;
                pick = starved[idx];
            end else begin
                idx = int'(ptr) + p - REQUESTERS;
                if (idx >= REQUESTERS) idx = idx - REQUESTERS;
                pick = elig[idx];
            end
            if (pick && !nxt_grant[idx] && free != '0) begin
                lane                          = lowest(free);
                nxt_grant[idx]                = 1'b1;
                nxt_lane[idx*LW +: LW]        = lane;
                nxt_valid[lane]               = 1'b1;
                nxt_owner[int'(lane)*OW +: OW] = OW'(idx);
                free[lane]                    = 1'b0;
                last                          = OW'(idx);
                any                           = 1'b1;
            end
        end
        nxt_ptr = ptr;
        if (any)
            nxt_ptr = (last == OW'(REQUESTERS - 1)) ? '0 : last + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            grant      <= '0;
            grant_lane <= '0;
            lane_valid <= '0;
            lane_owner <= '0;
            ptr        <= '0;
        end else begin
            grant      <= nxt_grant;
            grant_lane <= nxt_lane;
            lane_valid <= nxt_valid;
            lane_owner <= nxt_owner;
            ptr        <= nxt_ptr;
        end
    end

`ifdef CDB_ARB_STARVE_EN
    logic [CW-1:0] cnt [REQUESTERS];

    always_comb begin
        starved = '0;
        for (int i = 0; i < REQUESTERS; i++)
            starved[i] = elig[i] && (cnt[i] == CW'(STARVE_MAX));
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < REQUESTERS; i++) begin
            if (reset || clear || nxt_grant[i])
                cnt[i] <= '0;
            else if (request[i] && !grant[i] && cnt[i] != CW'(STARVE_MAX))
                cnt[i] <= cnt[i] + 1'b1;
        end
    end
`else
    logic [CW-1:0] unused_starve;

    assign starved       = '0;
    assign unused_starve = CW'(STARVE_MAX);
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: scoreboard bench for cdb_arbiter (5 requesters, 2 lanes).
module tb_cdb_arbiter;

`ifdef CDB_ARB_STARVE_EN
    localparam int SM = 3;
`else
    localparam int SM = 7;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       clear = 1'b0;
    logic [4:0] request = '0;
    logic [1:0] bus_available = '0;
    logic [4:0] grant;
    logic [4:0] grant_lane;
    logic [1:0] lane_valid;
    logic [5:0] lane_owner;

    cdb_arbiter #(
        .REQUESTERS(5),
        .BUSES(2),
        .STARVE_MAX(SM)
    ) dut (
        .clock(clock),
        .reset(reset),
        .clear(clear),
        .request(request),
        .bus_available(bus_available),
        .grant(grant),
        .grant_lane(grant_lane),
        .lane_valid(lane_valid),
        .lane_owner(lane_owner)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [4:0] g;
        logic [4:0] gl;
        logic [1:0] v;
        logic [5:0] lo;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    int         m_ptr = 0;
    logic [4:0] m_grant = '0;
    int         m_cnt [5] = '{default: 0};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Reference: list of units in priority order, lanes handed out from a queue.
    task automatic model_step();
        exp_t       e;
        int         lanes[$];
        int         order[$];
        logic [4:0] elig;
        logic [4:0] taken;
        int         last;
        e = '0;
        if (reset || clear) begin
            m_ptr   = 0;
            m_grant = '0;
            foreach (m_cnt[i]) m_cnt[i] = 0;
        end else begin
            taken = '0;
            last  = -1;
            elig  = request & ~m_grant;
            for (int k = 0; k < 2; k++)
                if (bus_available[k]) lanes.push_back(k);
`ifdef CDB_ARB_STARVE_EN
            for (int i = 0; i < 5; i++)
                if (elig[i] && m_cnt[i] == SM) begin
                    order.push_back(i);
                    taken[i] = 1'b1;
                end
`endif
            for (int j = 0; j < 5; j++) begin
                int u;
                u = (m_ptr + j) % 5;
                if (elig[u] && !taken[u]) order.push_back(u);
            end
            foreach (order[n]) begin
                if (lanes.size() > 0) begin
                    int l;
                    int u;
                    u = order[n];
                    l = lanes.pop_front();
                    e.g[u]          = 1'b1;
                    e.gl[u]         = l[0];
                    e.v[l]          = 1'b1;
                    e.lo[l*3 +: 3]  = 3'(u);
                    last            = u;
                end
            end
            for (int i = 0; i < 5; i++) begin
                if (e.g[i]) m_cnt[i] = 0;
                else if (request[i] && !m_grant[i] && m_cnt[i] < SM) m_cnt[i]++;
            end
            if (last >= 0) m_ptr = (last + 1) % 5;
            m_grant = e.g;
        end
        sb.push_back(e);
    endtask

    task automatic cyc(input logic rs, input logic cl,
                       input logic [4:0] rq, input logic [1:0] ba);
        exp_t e;
        @(negedge clock);
        reset         = rs;
        clear         = cl;
        request       = rq;
        bus_available = ba;
        model_step();
        @(posedge clock);
        #1;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk("grant", 32'(grant), 32'(e.g));
            chk("lane_valid", 32'(lane_valid), 32'(e.v));
            chk("grant_lane", 32'(grant_lane), 32'(e.gl));
            chk("lane_owner", 32'(lane_owner), 32'(e.lo));
        end
    endtask

    logic [4:0] rr_seq [5] = '{5'b00011, 5'b01100, 5'b10001, 5'b00110, 5'b11000};

    initial begin
        int hit;

        cyc(1'b1, 1'b0, 5'b11111, 2'b11);
        chk("t1_rst_grant", 32'(grant), 32'd0);
        cyc(1'b1, 1'b0, 5'b11111, 2'b11);
        chk("t1_rst_valid", 32'(lane_valid), 32'd0);
        cyc(1'b0, 1'b0, 5'b11111, 2'b11);
        chk("t1_first", 32'(grant), 32'b00011);

        cyc(1'b1, 1'b0, 5'b00000, 2'b11);
        cyc(1'b0, 1'b0, 5'b10110, 2'b11);
        chk("t2_grant", 32'(grant), 32'b00110);
        chk("t2_owner", 32'(lane_owner), 32'b010001);
        cyc(1'b0, 1'b0, 5'b10110, 2'b11);
        chk("t2_grant2", 32'(grant), 32'b10000);
        chk("t2_valid2", 32'(lane_valid), 32'b01);

        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 1'b0, 5'b11111, 2'b11);
            chk("t3_rr", 32'(grant), 32'(rr_seq[i % 5]));
        end

        cyc(1'b1, 1'b0, 5'b00000, 2'b11);
        cyc(1'b0, 1'b0, 5'b00011, 2'b10);
        chk("t4_grant", 32'(grant), 32'b00001);
        chk("t4_lane", 32'(grant_lane), 32'b00001);
        chk("t4_valid", 32'(lane_valid), 32'b10);
        cyc(1'b0, 1'b0, 5'b00010, 2'b10);
        chk("t4_unit1", 32'(grant), 32'b00010);
        chk("t4_owner", 32'(lane_owner), 32'b001000);

        cyc(1'b0, 1'b1, 5'b01000, 2'b11);
        chk("t5_clear", 32'(grant), 32'd0);
        cyc(1'b0, 1'b0, 5'b01000, 2'b11);
        chk("t5_unit3", 32'(grant), 32'b01000);
        chk("t5_owner", 32'(lane_owner), 32'b000011);

`ifdef CDB_ARB_STARVE_EN
        cyc(1'b1, 1'b0, 5'b00000, 2'b01);
        hit = 0;
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b0, 1'b0, 5'b11111, 2'b01);
            if (grant[4] && hit == 0) hit = i;
        end
        chk("t6_starve", 32'(hit >= 1 && hit <= 5), 32'd1);
`else
        hit = 0;
`endif

        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 99) == 0),
                ($urandom_range(0, 19) == 0),
                5'($urandom),
                2'($urandom));
        end

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
